// File: rtl/load_sequencer_if.sv
// Request/issue bundle between producer, load_sequencer and the counter.
interface load_sequencer_if #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic              req_valid_i;
  logic [DATA_W-1:0] req_val_i;
  logic              req_ready_o;
  logic              flush_i;
  logic              hold_i;
  logic              load_o;
  logic [DATA_W-1:0] load_val_o;
  logic [LW-1:0]     level_o;
  logic              busy_o;

  modport master (
    output req_valid_i, req_val_i, flush_i, hold_i,
    input  req_ready_o, load_o, load_val_o, level_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_val_i, flush_i, hold_i,
    output req_ready_o, load_o, load_val_o, level_o, busy_o
  );
endinterface

// File: rtl/load_sequencer.sv
// Buffers load requests in a small FIFO and issues them to the counter as
// single-cycle load pulses separated by at least GAP idle cycles.
module load_sequencer #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int GAP    = 2
) (
  input  logic            clk,
  input  logic            reset,
  load_sequencer_if.slave bus
);
  localparam int         AW      = $clog2(DEPTH);
  localparam int         LW      = AW + 1;
  localparam logic [3:0] GAP_CNT = 4'(GAP);

  typedef enum logic {S_IDLE, S_GAP} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  state_t            state;
  logic [3:0]        cnt;
  logic              load_q;
  logic [DATA_W-1:0] load_val_q;
  logic              full, push, pop;

  // Ready looks only at occupancy, never at a same-cycle pop.
  assign full            = (level == LW'(DEPTH));
  assign bus.req_ready_o = !full && !bus.flush_i;
  assign push            = bus.req_valid_i && bus.req_ready_o;
  assign pop             = (state == S_IDLE) && (level != '0) && !bus.hold_i && !bus.flush_i;

  assign bus.load_o      = load_q;
  assign bus.load_val_o  = load_val_q;
  assign bus.level_o     = level;
  assign bus.busy_o      = (level != '0) || (state != S_IDLE) || load_q;

  // FIFO storage write; contents need no reset since level gates reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.req_val_i;
  end

  // FIFO pointers and occupancy; flush discards everything pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Issue FSM: pulse from IDLE, then sit in GAP for GAP cycles.
  // load_val_q is kept across flush so the counter input stays stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      load_q     <= 1'b0;
      load_val_q <= '0;
    end else if (bus.flush_i) begin
      state  <= S_IDLE;
      cnt    <= '0;
      load_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            load_q     <= 1'b1;
            load_val_q <= mem[rd_ptr];
            if (GAP != 0) begin
              state <= S_GAP;
              cnt   <= GAP_CNT;
            end
          end else begin
            load_q <= 1'b0;
          end
        end
        S_GAP: begin
          load_q <= 1'b0;
          cnt    <= cnt - 1'b1;
          if (cnt == 4'd1) state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_sequencer.sv
// Directed bench for load_sequencer: GAP=2 and GAP=0 builds side by side,
// each with a queue scoreboard of accepted values checked against pulses.
module tb_load_sequencer;
  localparam int DW = 4;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  logic [DW-1:0] q2[$];
  logic [DW-1:0] q0[$];
  int            p2[$];
  int            last2 = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_sequencer_if #(.DATA_W(DW), .DEPTH(DP)) bus ();
  load_sequencer_if #(.DATA_W(DW), .DEPTH(DP)) bus0 ();

  load_sequencer #(.DATA_W(DW), .DEPTH(DP), .GAP(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  load_sequencer #(.DATA_W(DW), .DEPTH(DP), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present v until accepted; rel>0 drops hold on the rel-th stalled cycle.
  task automatic push(input int sel, input logic [DW-1:0] v, input int rel,
                      output int acc, output int st);
    acc = -1;
    st  = 0;
    if (sel == 0) begin bus.req_val_i = v;  bus.req_valid_i = 1'b1;  end
    else          begin bus0.req_val_i = v; bus0.req_valid_i = 1'b1; end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((sel == 0) ? bus.req_ready_o : bus0.req_ready_o) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
      st++;
      if (st == rel) bus.hold_i = 1'b0;
    end
    bus.req_valid_i  = 1'b0;
    bus0.req_valid_i = 1'b0;
    chk("push_accepted", int'(acc >= 0), 1);
  endtask

  task automatic wait_pulse(output int at);
    at = -1;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (bus.load_o) begin at = cyc; break; end
    end
    chk("pulse_seen", int'(at >= 0), 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (q2.size() == 0 && q0.size() == 0 && !bus.busy_o && !bus0.busy_o) break;
      tick(1);
    end
    chk("drain_q2", q2.size(), 0);
    chk("drain_q0", q0.size(), 0);
    chk("drain_busy", int'(bus.busy_o), 0);
  endtask

  // Scoreboard for the GAP=2 build: pulses pop, accepted requests push.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.load_o) begin
        chk("pulse_pending", int'(q2.size() != 0), 1);
        if (q2.size() != 0) chk("pulse_val", int'(bus.load_val_o), int'(q2.pop_front()));
        if (last2 >= 0) chk("pulse_spacing_min", int'(cyc - last2 >= 3), 1);
        last2 = cyc;
        p2.push_back(cyc);
      end
      if (bus.req_valid_i && bus.req_ready_o) q2.push_back(bus.req_val_i);
      if (bus.flush_i) begin q2.delete(); last2 = -1; end
    end
  end

  // Scoreboard for the GAP=0 build.
  always @(negedge clk) begin
    if (reset) begin
      if (bus0.load_o) begin
        chk("pulse0_pending", int'(q0.size() != 0), 1);
        if (q0.size() != 0) chk("pulse0_val", int'(bus0.load_val_o), int'(q0.pop_front()));
      end
      if (bus0.req_valid_i && bus0.req_ready_o) q0.push_back(bus0.req_val_i);
      if (bus0.flush_i) q0.delete();
    end
  end

  // Reset wipes all pending expectations.
  always @(negedge reset) begin
    q2.delete();
    q0.delete();
    last2 = -1;
  end

  initial begin
    int acc, st, at, rel_cyc;
    reset = 1'b0;
    bus.req_valid_i = 1'b0; bus.req_val_i = '0; bus.flush_i = 1'b0; bus.hold_i = 1'b0;
    bus0.req_valid_i = 1'b0; bus0.req_val_i = '0; bus0.flush_i = 1'b0; bus0.hold_i = 1'b0;
    tick(2);

    // Reset state
    chk("rst_load", int'(bus.load_o), 0);
    chk("rst_load_val", int'(bus.load_val_o), 0);
    chk("rst_level", int'(bus.level_o), 0);
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_ready", int'(bus.req_ready_o), 1);
    chk("rst0_level", int'(bus0.level_o), 0);
    @(negedge clk) reset = 1'b1;
    tick(1);

    // Single request: one-cycle latency, GAP then idle
    push(0, 4'h9, -1, acc, st);
    chk("t1_level_after_push", int'(bus.level_o), 1);
    chk("t1_no_issue_same_edge", int'(bus.load_o), 0);
    tick(1);
    chk("t1_load", int'(bus.load_o), 1);
    chk("t1_load_val", int'(bus.load_val_o), 9);
    chk("t1_level", int'(bus.level_o), 0);
    tick(1);
    chk("t1_pulse_one_cycle", int'(bus.load_o), 0);
    chk("t1_val_held", int'(bus.load_val_o), 9);
    chk("t1_busy_gap", int'(bus.busy_o), 1);
    tick(1);
    chk("t1_busy_done", int'(bus.busy_o), 0);

    // Burst 1..5: fill under hold, 5 stalls until the first pop
    p2.delete();
    bus.hold_i = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      push(0, 4'(v), -1, acc, st);
      chk("t2_no_stall", st, 0);
    end
    chk("t2_level_full", int'(bus.level_o), 4);
    chk("t2_ready_full", int'(bus.req_ready_o), 0);
    push(0, 4'h5, 2, acc, st);
    chk("t2_stalls", st, 2);
    chk("t2_accept_after_pop", acc, (p2.size() > 0) ? p2[0] + 1 : -1);
    drain();
    chk("t2_pulse_count", p2.size(), 5);
    for (int i = 1; i < 5 && i < p2.size(); i++) chk("t2_spacing", p2[i] - p2[i-1], 3);

    // Hold buffers without issuing
    p2.delete();
    bus.hold_i = 1'b1;
    push(0, 4'h7, -1, acc, st);
    push(0, 4'h8, -1, acc, st);
    tick(4);
    chk("t3_level_held", int'(bus.level_o), 2);
    chk("t3_no_pulse", p2.size(), 0);
    bus.hold_i = 1'b0;
    rel_cyc = cyc;
    drain();
    chk("t3_pulse_count", p2.size(), 2);
    if (p2.size() == 2) begin
      chk("t3_first_after_release", p2[0], rel_cyc + 1);
      chk("t3_spacing", p2[1] - p2[0], 3);
    end

    // Flush during GAP
    p2.delete();
    bus.hold_i = 1'b1;
    push(0, 4'hB, -1, acc, st);
    push(0, 4'hC, -1, acc, st);
    push(0, 4'hD, -1, acc, st);
    bus.hold_i = 1'b0;
    wait_pulse(at);
    chk("t4_first_val", int'(bus.load_val_o), 11);
    tick(1);
    bus.flush_i = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_val_i = 4'hE;
    @(negedge clk);
    chk("t4_ready_flush", int'(bus.req_ready_o), 0);
    tick(1);
    bus.flush_i = 1'b0;
    bus.req_valid_i = 1'b0;
    chk("t4_level", int'(bus.level_o), 0);
    chk("t4_load", int'(bus.load_o), 0);
    chk("t4_busy", int'(bus.busy_o), 0);
    tick(10);
    chk("t4_no_more_pulses", p2.size(), 1);
    chk("t4_val_kept", int'(bus.load_val_o), 11);
    chk("t4_level_still", int'(bus.level_o), 0);

    // Asynchronous reset mid-pulse
    bus.hold_i = 1'b1;
    push(0, 4'h5, -1, acc, st);
    push(0, 4'h6, -1, acc, st);
    bus.hold_i = 1'b0;
    wait_pulse(at);
    #2 reset = 1'b0;
    #1;
    chk("t5_load", int'(bus.load_o), 0);
    chk("t5_level", int'(bus.level_o), 0);
    chk("t5_busy", int'(bus.busy_o), 0);
    chk("t5_load_val", int'(bus.load_val_o), 0);
    @(negedge clk) reset = 1'b1;
    tick(1);
    push(0, 4'hA, -1, acc, st);
    tick(1);
    chk("t5_new_load", int'(bus.load_o), 1);
    chk("t5_new_val", int'(bus.load_val_o), 10);
    drain();

    // GAP=0 build: consecutive pulses
    bus0.hold_i = 1'b1;
    push(1, 4'h3, -1, acc, st);
    push(1, 4'h6, -1, acc, st);
    push(1, 4'hC, -1, acc, st);
    chk("t6_level", int'(bus0.level_o), 3);
    bus0.hold_i = 1'b0;
    tick(1);
    chk("t6_p1", int'(bus0.load_o), 1);
    chk("t6_v1", int'(bus0.load_val_o), 3);
    tick(1);
    chk("t6_p2", int'(bus0.load_o), 1);
    chk("t6_v2", int'(bus0.load_val_o), 6);
    tick(1);
    chk("t6_p3", int'(bus0.load_o), 1);
    chk("t6_v3", int'(bus0.load_val_o), 12);
    tick(1);
    chk("t6_end", int'(bus0.load_o), 0);
    chk("t6_level_end", int'(bus0.level_o), 0);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/load_sequencer.md
Name: load_sequencer

Overview:
- Upstream feeder for the loadable 4-bit counter. Accepts load requests from a producer over a valid/ready handshake and buffers them in a small FIFO.
- Issues each buffered value to the counter as a single-cycle load pulse (`load_o` with `load_val_o`), with a guaranteed minimum idle spacing between pulses.
- `load_o` / `load_val_o` connect directly to the counter's `load_i` / `load_val_i`.

Parameters:
- DATA_W, 4, width of load value; matches counter width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- GAP, 2, minimum low cycles of `load_o` between two pulses; 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk externally.
- req_valid_i  in  1  producer has a load value.
- req_val_i  in  DATA_W  value to load.
- req_ready_o  out  1  block accepts; transfer occurs on an edge where valid&&ready.
- flush_i  in  1  synchronous discard of all pending requests.
- hold_i  in  1  pause issuance; buffering continues.
- load_o  out  1  one-cycle load strobe to counter.
- load_val_o  out  DATA_W  value accompanying `load_o`; holds last issued value otherwise.
- level_o  out  clog2(DEPTH)+1  current FIFO occupancy.
- busy_o  out  1  high while FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (reset==0): FIFO empty, level_o=0, load_o=0, load_val_o=0, state=IDLE, gap counter=0, busy_o=0, req_ready_o=1 once flush_i low.
- req_ready_o = !full && !flush_i. It must not depend on a same-cycle pop, so a full FIFO refuses a push even when popping in that cycle.
- Push: on edge with req_valid_i && req_ready_o, write req_val_i at the tail; level +1.
- FSM states: IDLE, GAP. Outputs are registered.
- IDLE: on an edge where level!=0 && !hold_i && !flush_i:
  - load_o<=1, load_val_o<=head, pop (level -1).
  - State<=GAP with counter=GAP; if GAP==0, stay in IDLE.
  - Otherwise load_o<=0.
- GAP: load_o<=0; counter decrements each edge; when counter reaches 1, state<=IDLE. hold_i has no effect in GAP.
- Latency: a request accepted at edge N into an empty, idle, unheld block gives load_o high during cycle N+1 → N+2 (one cycle after acceptance).
- Spacing: back-to-back pending entries give load_o pulses exactly GAP+1 cycles apart (GAP low cycles between). With GAP=0, load_o stays high on consecutive cycles, one entry per cycle.
- Simultaneous push and pop (not full): both occur; level unchanged.
- Pushing into an empty FIFO on the same edge the FSM samples: no issue that edge (level was 0). Issue occurs next edge.
- flush_i (synchronous, highest priority):
  - Next edge: level=0, pointers reset, state=IDLE, counter=0, load_o=0.
  - load_val_o retains its last value.
  - A request presented during flush is not accepted.
- hold_i rising while in GAP: GAP completes, then the FSM waits in IDLE. Deasserting hold_i allows issue on the next edge.
- Asynchronous reset mid-GAP or mid-pulse: all state cleared immediately; load_o drops without waiting for clk.
- Pointers wrap modulo DEPTH. level_o reaches DEPTH exactly when full.
- busy_o = (level!=0) || (state!=IDLE) || load_o.

Test Plan (DATA_W=4, DEPTH=4, GAP=2):
- Single request 4'h9 accepted at edge 3 → load_o=1 only in cycle after edge 4, load_val_o=9, stays 9 afterwards; level returns to 0; busy_o falls after GAP expires.
- Burst 1,2,3,4,5 with valid held → first four accepted; 5 is stalled (ready=0) until the first pop. Pulses carry 1,2,3,4,5 in order, each 3 cycles apart.
- hold_i=1, push 7 and 8 → no pulses, level_o=2; release hold_i → pulses 7 then 8 spaced 3 cycles.
- Three entries queued, flush_i pulsed one cycle during GAP → no further load_o, level_o=0, load_val_o keeps the last issued value.
- reset driven low mid-burst, between clock edges → load_o, level_o, busy_o go 0 immediately; load_val_o=0; after release, new request 4'hA issues normally.
- Rebuild with GAP=0, push 3,6,C back-to-back → load_o high three consecutive cycles with values 3,6,C.
